// File: rtl/esfa_op_arbiter.sv
// esfa_op_arbiter
//   Shares the single ESFA datapath between two requesters. One command is
//   accepted at a time, its operands are issued to the datapath with a
//   single-cycle write strobe, the result is captured RESULT_LATENCY cycles
//   later, and it is returned to the originating requester.
//
// Build option:
//   ESFA_ARB_ROUND_ROBIN_EN  defined   -> round-robin grant when both requesters
//                                         are valid (alternates against lastGrant)
//                            undefined -> fixed priority, requester 0 wins
//
// Parameters:
//   RESULT_LATENCY  cycles from operand issue to datapath result (legal 1..15)
//
// Ports:
//   masterClock, reset         clock (rising edge), async active-low reset
//   reqN_valid/ready/cmd       command channels, cmd = {write, isMetadata,
//                              selector, metadata, value, index}
//   rspN_valid/ready           response channels (one per requester)
//   rsp_bool, rsp_value        shared response payload, qualified by rspN_valid
//   esfa_*                     datapath operands, write strobe and result inputs
//   busy                       high whenever not IDLE
//   dbgState                   FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RESPOND)
//
// Handshake: on every channel a transfer happens on a rising edge where valid
// and ready are both high. A producer may drop valid before a transfer with no
// effect; ready seen while valid is low is ignored.
module esfa_op_arbiter #(
  parameter int RESULT_LATENCY = 2
) (
  input  logic        masterClock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [33:0] req0_cmd,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [33:0] req1_cmd,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic        rsp_bool,
  output logic [7:0]  rsp_value,
  output logic        esfa_willWrite,
  output logic [7:0]  esfa_index,
  output logic [7:0]  esfa_value,
  output logic [7:0]  esfa_metadata,
  output logic [7:0]  esfa_selector,
  output logic        esfa_isMetadata,
  input  logic        esfa_resultBool,
  input  logic [7:0]  esfa_resultValue,
  output logic        busy,
  output logic [1:0]  dbgState
);

  localparam logic [3:0] LAT4 = 4'(RESULT_LATENCY);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } arbStateT;

  arbStateT    state, nextState;
  logic [33:0] cmdReg;
  logic        owner;      // 0 = requester 0, 1 = requester 1
  logic [3:0]  waitCnt;
  logic        grant;      // requester chosen in IDLE
  logic        accept;
  logic        rspHandshake;

`ifdef ESFA_ARB_ROUND_ROBIN_EN
  logic lastGrant;
`endif

  // Grant selection: only matters in IDLE; a lone valid requester always wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ESFA_ARB_ROUND_ROBIN_EN
      grant = ~lastGrant;
`else
      grant = 1'b0;
`endif
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // reset is folded in so ready drops the instant reset asserts.
  assign req0_ready   = (state == IDLE) & ~grant & req0_valid & reset;
  assign req1_ready   = (state == IDLE) &  grant & req1_valid & reset;
  assign accept       = req0_ready | req1_ready;
  assign rspHandshake = (state == RESPOND) & (owner ? rsp1_ready : rsp0_ready);

  // State register
  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (accept)           nextState = ISSUE;
      ISSUE:                         nextState = WAIT;
      WAIT:    if (waitCnt == 4'd1)  nextState = RESPOND;
      RESPOND: if (rspHandshake)     nextState = IDLE;
      default:                       nextState = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy           = 1'b0;
    esfa_willWrite = 1'b0;
    rsp0_valid     = 1'b0;
    rsp1_valid     = 1'b0;
    unique case (state)
      IDLE: ;
      ISSUE: begin
        busy           = 1'b1;
        esfa_willWrite = cmdReg[33];
      end
      WAIT:  busy = 1'b1;
      RESPOND: begin
        busy       = 1'b1;
        rsp0_valid = ~owner;
        rsp1_valid =  owner;
      end
      default: ;
    endcase
  end

  // Operands come straight from the latched command, so they stay stable
  // through ISSUE and WAIT and read as zero after reset.
  assign esfa_index      = cmdReg[7:0];
  assign esfa_value      = cmdReg[15:8];
  assign esfa_metadata   = cmdReg[23:16];
  assign esfa_selector   = cmdReg[31:24];
  assign esfa_isMetadata = cmdReg[32];
  assign dbgState        = state;

  // Command latch, wait counter and result capture
  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      cmdReg    <= '0;
      owner     <= 1'b0;
      waitCnt   <= '0;
      rsp_bool  <= 1'b0;
      rsp_value <= '0;
    end else begin
      if (accept) begin
        cmdReg <= grant ? req1_cmd : req0_cmd;
        owner  <= grant;
      end
      if (state == ISSUE) begin
        waitCnt <= LAT4;
      end else if (state == WAIT && waitCnt != 4'd1) begin
        waitCnt <= waitCnt - 4'd1;
      end
      // Last WAIT cycle: the datapath result is valid on this edge.
      if (state == WAIT && waitCnt == 4'd1) begin
        if (cmdReg[33]) begin
          rsp_bool  <= 1'b1;   // writes only acknowledge
          rsp_value <= 8'h00;
        end else begin
          rsp_bool  <= esfa_resultBool;
          rsp_value <= esfa_resultValue;
        end
      end
    end
  end

`ifdef ESFA_ARB_ROUND_ROBIN_EN
  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset)      lastGrant <= 1'b1;
    else if (accept) lastGrant <= grant;
  end
`endif

endmodule

// File: tb/tb_esfa_op_arbiter.sv
`timescale 1ns/1ps
module tb_esfa_op_arbiter;

  localparam int LAT = 2;

  // ---------------- clock / reset ----------------
  logic        masterClock = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [33:0] req0_cmd = '0, req1_cmd = '0;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic        rsp_bool;
  logic [7:0]  rsp_value;
  logic        esfa_willWrite, esfa_isMetadata;
  logic [7:0]  esfa_index, esfa_value, esfa_metadata, esfa_selector;
  logic        esfa_resultBool = 1'b0;
  logic [7:0]  esfa_resultValue = '0;
  logic        busy;
  logic [1:0]  dbgState;

  always #5 masterClock = ~masterClock;

  esfa_op_arbiter #(.RESULT_LATENCY(LAT)) dut (
    .masterClock(masterClock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_bool(rsp_bool), .rsp_value(rsp_value),
    .esfa_willWrite(esfa_willWrite), .esfa_index(esfa_index),
    .esfa_value(esfa_value), .esfa_metadata(esfa_metadata),
    .esfa_selector(esfa_selector), .esfa_isMetadata(esfa_isMetadata),
    .esfa_resultBool(esfa_resultBool), .esfa_resultValue(esfa_resultValue),
    .busy(busy), .dbgState(dbgState)
  );

  // ---------------- scoreboard state ----------------
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [9:0]  exp_q[$];        // {owner, bool, value}
  int          accCyc_q[$];
  int          grantLog[$];
  bit          inFlight = 0;
  int          acceptCyc = 0;
  logic [33:0] curCmd = '0;
  bit          lastGrantM = 1;
  bit          rspSeen = 0;
  bit          acc0 = 0, acc1 = 0, hs = 0;
  logic [33:0] accCmd = '0;
  bit          expRdy0, expRdy1;
  int          rdyMode = 0;      // 0 ready, 1 random, 2 rsp0 held low, 3 rsp1 held low

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural datapath: result is an arithmetic function of the operands.
  function automatic logic [7:0] dpValue(input logic [33:0] c);
    return (c[7:0] + c[15:8]) ^ c[31:24];
  endfunction
  function automatic logic dpBool(input logic [33:0] c);
    return c[32] ^ (c[7:0] > c[23:16]);
  endfunction
  function automatic logic [8:0] expResult(input logic [33:0] c);
    if (c[33]) return {1'b1, 8'h00};
    return {dpBool(c), dpValue(c)};
  endfunction
  function automatic logic [33:0] randCmd();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[33:0];
  endfunction

  task automatic resetModel();
    inFlight = 0; rspSeen = 0; acc0 = 0; acc1 = 0; hs = 0; lastGrantM = 1;
    exp_q.delete(); accCyc_q.delete();
  endtask

  // ---------------- reference model + monitor (negedge) ----------------
  initial forever begin
    @(negedge masterClock);
    if (reset) begin
      expRdy0 = 0; expRdy1 = 0;
      if (!inFlight) begin
        if (req0_valid && req1_valid) begin
`ifdef ESFA_ARB_ROUND_ROBIN_EN
          expRdy0 = lastGrantM; expRdy1 = !lastGrantM;
`else
          expRdy0 = 1;
`endif
        end else begin
          expRdy0 = req0_valid; expRdy1 = req1_valid;
        end
      end
      check("req0_ready", req0_ready, expRdy0);
      check("req1_ready", req1_ready, expRdy1);
      check("busy", busy, inFlight);
      check("willWrite", esfa_willWrite, inFlight && cyc == acceptCyc && curCmd[33]);
      if (inFlight && cyc <= acceptCyc + LAT)
        check("operands", {esfa_isMetadata, esfa_selector, esfa_metadata, esfa_value, esfa_index},
              curCmd[32:0]);
      // datapath presents the true result only in the cycle before the capture edge
      if (inFlight && cyc == acceptCyc + LAT) begin
        esfa_resultBool = dpBool(curCmd); esfa_resultValue = dpValue(curCmd);
      end else begin
        esfa_resultBool = ~dpBool(curCmd); esfa_resultValue = ~dpValue(curCmd);
      end
      if (rsp0_valid || rsp1_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", {rsp1_valid, rsp0_valid}, 2'b00);
        end else begin
          check("rsp_owner", {rsp1_valid, rsp0_valid}, exp_q[0][9] ? 2'b10 : 2'b01);
          check("rsp_result", {rsp_bool, rsp_value}, exp_q[0][8:0]);
          if (!rspSeen) begin
            check("rsp_latency", cyc - accCyc_q[0], LAT + 1);
            rspSeen = 1;
          end
        end
      end
      if (inFlight && cyc - acceptCyc > 300) begin
        check("rsp_timeout", 1'b0, 1'b1);
        resetModel();
      end
      acc0   = req0_valid && req0_ready;
      acc1   = req1_valid && req1_ready;
      accCmd = acc1 ? req1_cmd : req0_cmd;
      hs     = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
    end
  end

  // model state advances on the edge where the predicted transfers happen
  initial forever begin
    @(posedge masterClock);
    cyc++;
    if (hs) begin
      inFlight = 0; rspSeen = 0; hs = 0;
      if (exp_q.size() != 0) begin
        void'(exp_q.pop_front()); void'(accCyc_q.pop_front());
      end
    end
    if (acc0 || acc1) begin
      inFlight = 1; acceptCyc = cyc; curCmd = accCmd; lastGrantM = acc1;
      grantLog.push_back(acc1 ? 1 : 0);
      exp_q.push_back({acc1, expResult(accCmd)});
      accCyc_q.push_back(cyc);
      acc0 = 0; acc1 = 0;
    end
  end

  // ---------------- response consumers ----------------
  initial forever begin
    @(posedge masterClock); #1;
    case (rdyMode)
      0: begin rsp0_ready = 1; rsp1_ready = 1; end
      1: begin rsp0_ready = ($urandom_range(0, 2) == 0); rsp1_ready = ($urandom_range(0, 2) == 0); end
      2: begin rsp0_ready = 0; rsp1_ready = 1; end
      default: begin rsp0_ready = 1; rsp1_ready = 0; end
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic sendCmd(input bit r, input logic [33:0] c, input int holdMax, output bit taken);
    @(posedge masterClock); #1;
    if (r) begin req1_cmd = c; req1_valid = 1; end
    else   begin req0_cmd = c; req0_valid = 1; end
    taken = 0;
    for (int i = 0; i < holdMax && !taken; i++) begin
      @(negedge masterClock);
      taken = r ? (req1_ready === 1'b1) : (req0_ready === 1'b1);
      @(posedge masterClock); #1;
    end
    if (r) req1_valid = 0; else req0_valid = 0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while ((inFlight || exp_q.size() != 0) && n < budget) begin
      @(negedge masterClock); n++;
    end
    check("drain_done", inFlight, 1'b0);
    @(posedge masterClock); #1;
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_rsp_valid"}, {rsp1_valid, rsp0_valid}, 2'b00);
    check({tag, "_rsp_payload"}, {rsp_bool, rsp_value}, 9'h000);
    check({tag, "_esfa"}, {esfa_willWrite, esfa_isMetadata, esfa_selector, esfa_metadata,
                           esfa_value, esfa_index}, 34'h0);
    check({tag, "_req_ready"}, {req1_ready, req0_ready}, 2'b00);
    check({tag, "_state"}, dbgState, 2'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  bit taken, taken0, taken1;
  int n;
  int expG[4];

  initial begin
    // reset with requests already pending: nothing may be accepted
    req0_valid = 1; req1_valid = 1;
    repeat (3) @(posedge masterClock);
    #2;
    checkResetValues("reset");
    req0_valid = 0; req1_valid = 0;
    @(posedge masterClock); #3;
    reset = 1;

    // read from requester 0
    sendCmd(0, {1'b0, 1'b0, 8'h11, 8'h22, 8'h00, 8'h05}, 20, taken);
    check("read0_taken", taken, 1'b1);
    waitIdle(60);

    // write from requester 1
    sendCmd(1, {1'b1, 1'b0, 8'h00, 8'h00, 8'h42, 8'h03}, 20, taken);
    check("write1_taken", taken, 1'b1);
    waitIdle(60);

    // both requesters valid continuously
    grantLog.delete();
    req0_cmd = randCmd(); req1_cmd = randCmd();
    req0_valid = 1; req1_valid = 1;
    n = 0;
    while (grantLog.size() < 4 && n < 200) begin
      @(posedge masterClock); #1; n++;
    end
    req0_valid = 0; req1_valid = 0;
`ifdef ESFA_ARB_ROUND_ROBIN_EN
    expG = '{0, 1, 0, 1};
`else
    expG = '{0, 0, 0, 0};
`endif
    check("grant_count", grantLog.size() >= 4, 1'b1);
    for (int i = 0; i < 4 && i < grantLog.size(); i++) check("grant_order", grantLog[i], expG[i]);
    waitIdle(100);

    // response back-pressure on requester 0 while requester 1 waits
    rdyMode = 2;
    sendCmd(0, {1'b0, 1'b1, 8'h5A, 8'h10, 8'h33, 8'h44}, 20, taken);
    check("hold_taken", taken, 1'b1);
    req1_cmd = randCmd(); req1_valid = 1;
    repeat (LAT + 12) begin @(posedge masterClock); #1; end
    check("hold_rsp0_valid", rsp0_valid, 1'b1);
    req1_valid = 0;
    rdyMode = 0;
    waitIdle(60);

    // reset pulse during WAIT
    sendCmd(0, {1'b0, 1'b0, 8'h77, 8'h01, 8'h02, 8'h09}, 20, taken);
    check("rstwait_taken", taken, 1'b1);
    @(posedge masterClock); #2;
    check("rstwait_in_wait", dbgState, 2'd2);
    reset = 0;
    resetModel();
    #1;
    checkResetValues("midreset");
    repeat (2) @(posedge masterClock);
    #3;
    reset = 1;
    repeat (LAT + 4) @(posedge masterClock);
    #1;
    sendCmd(0, {1'b0, 1'b0, 8'h0F, 8'h80, 8'hF0, 8'h81}, 20, taken);
    check("after_reset_taken", taken, 1'b1);
    waitIdle(60);

    // requester 0 pulses valid while requester 1 sits in RESPOND
    rdyMode = 3;
    sendCmd(1, {1'b0, 1'b0, 8'hC3, 8'h3C, 8'h99, 8'h66}, 20, taken);
    check("respond_taken", taken, 1'b1);
    n = 0;
    while (rsp1_valid !== 1'b1 && n < 20) begin @(posedge masterClock); #1; n++; end
    check("respond_reached", rsp1_valid, 1'b1);
    req0_cmd = {1'b1, 1'b0, 8'hAA, 8'hBB, 8'hCC, 8'hDD}; req0_valid = 1;
    @(posedge masterClock); #1;
    req0_valid = 0;
    repeat (3) @(posedge masterClock);
    #1;
    rdyMode = 0;
    waitIdle(60);

    // randomized traffic from both requesters
    rdyMode = 1;
    fork
      for (int k = 0; k < 25; k++) begin
        repeat ($urandom_range(0, 4)) @(posedge masterClock);
        sendCmd(0, randCmd(), $urandom_range(1, 30), taken0);
      end
      for (int k = 0; k < 25; k++) begin
        repeat ($urandom_range(0, 4)) @(posedge masterClock);
        sendCmd(1, randCmd(), $urandom_range(1, 30), taken1);
      end
    join
    rdyMode = 0;
    waitIdle(200);

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/esfa_op_arbiter.md
# esfa_op_arbiter

Sequences and shares the single ESFA datapath between two independent requesters (e.g. host-link sandbox process and an on-chip scrubber). It accepts one command at a time, drives the datapath's operand inputs with a single-cycle write strobe, waits a fixed result latency, and returns the captured result to the originating requester over a valid/ready response channel. The block sits between the requester front-ends and the ESFA datapath instance inside the sandbox.

## Interface
- RESULT_LATENCY, 2, cycles from operand issue to datapath result valid; legal range 1..15
- masterClock  in  1  operating clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  requester N has a command pending
- req0_ready / req1_ready  out  1  command accepted on this edge when valid & ready
- req0_cmd / req1_cmd  in  34  {write[33], isMetadata[32], selector[31:24], metadata[23:16], value[15:8], index[7:0]}
- rsp0_valid / rsp1_valid  out  1  response available for requester N
- rsp0_ready / rsp1_ready  in  1  requester N consumes response
- rsp_bool  out  1  response result flag (shared, qualified by rspN_valid)
- rsp_value  out  8  response result value (shared)
- esfa_willWrite  out  1  datapath write strobe
- esfa_index, esfa_value, esfa_metadata, esfa_selector  out  8 each  datapath operands
- esfa_isMetadata  out  1  datapath operand
- esfa_resultBool  in  1  datapath result flag
- esfa_resultValue  in  8  datapath result value
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESPOND.
- IDLE: grant chosen combinationally among valid requesters; reqN_ready = (state==IDLE) & grant==N & reqN_valid & reset. On accept: latch cmd and owner ID, go ISSUE.
- ISSUE (1 cycle): esfa_* operands driven from latched cmd; esfa_willWrite = cmd.write for this cycle only. Load wait counter with RESULT_LATENCY; go WAIT.
- WAIT: operands held stable, willWrite 0; counter decrements; on reaching 1, capture result and go RESPOND.
- Capture: read op -> rsp_bool = esfa_resultBool, rsp_value = esfa_resultValue; write op -> rsp_bool = 1, rsp_value = 0x00 (datapath result ignored).
- RESPOND: rspN_valid high for owner only; rsp_bool/rsp_value held until rspN_ready, then IDLE. Other requester's rsp_valid stays 0.
- No new command accepted outside IDLE; requesters may drop valid before accept without effect.
- Reset values: state IDLE, all esfa_* outputs 0, rsp*_valid 0, rsp_bool 0, rsp_value 0, busy 0, reqN_ready 0, lastGrant = 1.
- Reset asserted mid-operation: in-flight command discarded, no response delivered, outputs to reset values immediately.

## Timing
- Accept at edge E0 -> ISSUE during E0..E1 -> WAIT during E1..E(1+RESULT_LATENCY) -> rspN_valid rises at edge E(1+RESULT_LATENCY).
- Result sampled at edge E(1+RESULT_LATENCY); datapath must present result RESULT_LATENCY cycles after operands appear.
- rspN_ready high at rising of rspN_valid: handshake at next edge, IDLE one cycle, next accept earliest at that IDLE edge. Minimum command period = RESULT_LATENCY + 3 cycles.
- rspN_ready high while rspN_valid low: ignored.

## Configuration
- ESFA_ARB_ROUND_ROBIN_EN defined: when both valid in IDLE, grant goes to requester other than lastGrant; lastGrant updated on each accept. Single valid requester always granted.
- Undefined: fixed priority, requester 0 always wins when both valid; lastGrant unused.

## Test plan
- Reset release, req0 read cmd index 0x05, RESULT_LATENCY=2, datapath returns bool 1 / value 0xA7 -> willWrite stays 0, rsp0_valid rises 3 edges after accept with rsp_bool 1, rsp_value 0xA7; rsp1_valid stays 0.
- req1 write cmd index 0x03 value 0x42 -> esfa_willWrite high exactly one cycle with esfa_index 0x03, esfa_value 0x42; rsp1 returns bool 1, value 0x00.
- Both valid continuously, round-robin build -> grants 0,1,0,1; fixed-priority build -> grants 0,0,0,0.
- rsp0_ready held low 10 cycles -> rsp0_valid and rsp_value stable, req1_ready stays 0, busy 1 throughout.
- Reset pulsed low during WAIT -> all outputs 0 asynchronously, no response after release, next req0 accepted normally.
- req0_valid pulsed for 1 cycle while block in RESPOND -> never accepted, no esfa_willWrite strobe.
